arena_access_arbiter: RTL and testbench
=======================================

# arena_access_arbiter

Sequencer and arbiter for the single shared read/write port of the 10x10 arena map and bomb map. Player A, player B and the explosion engine all request through it. It performs each request as an atomic read-check-write sequence, owns both player positions, and reports explosion hits. It sits between chara_control/bomb and the arena storage, and is the only writer of the maps during play.

## Interface
- GRID_W, default 10: arena row width.
- CELLS, default 100: arena cell count.
- ADDR_W, default 7: cell index width.

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- game_over  in  1  high blocks player grants; explosions are still served
- a_valid / b_valid  in  1  player request valid; held until ready
- a_cmd / b_cmd  in  3  0 up, 1 down, 2 left, 3 right, 4 place bomb, 5–7 illegal
- a_ready / b_ready  out  1  grant; valid&ready is the accept cycle
- a_done / b_done  out  1  one-cycle completion pulse
- a_ok / b_ok  out  1  result qualifier, meaningful only while done is high
- x_valid  in  1  explosion clear request
- x_addr  in  ADDR_W  cell to clear
- x_ready  out  1  explosion grant
- x_done  out  1  explosion completion pulse
- hit_a / hit_b  out  1  pulse when an explosion covers a player's cell
- a_pos / b_pos  out  ADDR_W  current player cell
- mem_addr  out  ADDR_W  shared address for arena and bomb map
- mem_rd_data  in  2  arena cell, valid one cycle after mem_addr
- bomb_rd_data  in  1  bomb cell, same latency
- mem_wr_en  out  1  arena write strobe
- mem_wr_data  out  2  arena write data
- bomb_wr_en  out  1  bomb map write of 1 at mem_addr

## Operation
- Arena codes: 0 empty, 1 block, 2 player A, 3 player B.
- FSM states: IDLE, RD, CHK, WR_NEW, WR_OLD.
- Ready signals are combinational and asserted only in IDLE. At most one ready is high at a time.
- Grant priority: x first. Between A and B, round-robin on the last-granted player; after reset A is favoured. With game_over high, a_ready and b_ready stay 0.
- Request fields are latched at accept.

Move commands:
- Target cell: up pos-10, down pos+10, left pos-1, right pos+1.
- Boundary reject, with no memory access: up with pos<10; down with pos>=90; left with pos%10==0; right with pos%10==9.
- IDLE→RD: mem_addr = target.
- RD→CHK: sample mem_rd_data. If nonzero: done, ok=0, return to IDLE.
- Otherwise WR_NEW: write the player code to target.
- Then WR_OLD: write 0 to the old pos. done, ok=1, and pos←target at the end of this cycle.

Bomb command (4):
- One cycle after accept: mem_addr=pos, bomb_wr_en=1, done, ok=1. No arena read.

Illegal cmd (5–7):
- done, ok=0 one cycle after accept. No memory access.

Explosion:
- RD at x_addr, then CHK.
- Code 2: hit_a pulse, no write.
- Code 3: hit_b pulse, no write.
- Else: WR_NEW writes 0 (this destroys blocks).
- x_done fires in the final cycle.

General rules:
- Outside write states, mem_wr_en, bomb_wr_en and mem_wr_data are 0.
- Position arithmetic is unsigned ADDR_W. Boundary checks precede subtraction, so no wrap occurs.

## Timing
- Accept cycle is T0, in IDLE.
- Boundary, illegal or bomb command: done at T1, back in IDLE at T2.
- Occupied target: RD at T1, done ok=0 at T2 (CHK), IDLE at T3.
- Accepted move: RD T1, CHK T2, WR_NEW T3, WR_OLD plus done T4. New pos is visible at T5, which is also the next possible accept.
- Explosion: hit at T2, or write at T3; x_done in the last busy cycle.
- Simultaneous x and player valid: x is granted and the player waits. Players are not starved, because x never wins two consecutive IDLE cycles while a player is waiting.
- Reset values: state IDLE; all ready/done/ok/hit/write strobes 0; mem_addr 0; mem_wr_data 0; a_pos 11; b_pos 88; round-robin pointer favours A.
- Reset mid-sequence: the sequence is abandoned at once and no further writes occur. Arena contents are not restored; the reset block owns map initialisation.

## Configuration
- BOMB_BLOCKS_MOVE_EN defined: in CHK, a move is also rejected (ok=0) when bomb_rd_data is 1.
- Undefined: bomb_rd_data is ignored and players may walk onto bombs.

## Test plan
- Reset, A right from 11 with arena[12]=0: mem_wr to 12 with data 2 at T3, to 11 with data 0 at T4, a_done/a_ok=1, a_pos=12.
- A up from pos 5: a_done, a_ok=0 at T1; no mem_wr_en; a_pos stays 5.
- A down into a block (arena[21]=1, pos 11): done ok=0 at T2; no writes.
- x_valid, a_valid, b_valid all high in the same cycle: x granted first, then A, then B; a_ready and b_ready are never high together.
- Explosion at 88 while B is there: hit_b pulse at T2, no write. Explosion at a block cell: write 0 at T3.
- Assert rst during WR_NEW: no WR_OLD write; positions return to 11/88; ready resumes after rst falls. With BOMB_BLOCKS_MOVE_EN, a bomb at the target gives ok=0.

Source files
------------

// File: rtl/arena_access_arbiter.sv
// Serialises player moves, bomb drops and explosion clears onto the single arena/bomb map port.
// Optional: define BOMB_BLOCKS_MOVE_EN to make bomb cells block player moves.
module arena_access_arbiter #(
  parameter int unsigned GRID_W = 10,
  parameter int unsigned CELLS  = 100,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              game_over,
  input  logic              a_valid,
  input  logic [2:0]        a_cmd,
  output logic              a_ready,
  output logic              a_done,
  output logic              a_ok,
  input  logic              b_valid,
  input  logic [2:0]        b_cmd,
  output logic              b_ready,
  output logic              b_done,
  output logic              b_ok,
  input  logic              x_valid,
  input  logic [ADDR_W-1:0] x_addr,
  output logic              x_ready,
  output logic              x_done,
  output logic              hit_a,
  output logic              hit_b,
  output logic [ADDR_W-1:0] a_pos,
  output logic [ADDR_W-1:0] b_pos,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_rd_data,
  input  logic              bomb_rd_data,
  output logic              mem_wr_en,
  output logic [1:0]        mem_wr_data,
  output logic              bomb_wr_en
);

  typedef enum logic [2:0] {IDLE, RD, CHK, WR_NEW, WR_OLD} state_e;
  typedef enum logic [1:0] {OP_MOVE, OP_BOMB, OP_REJ, OP_X} op_e;

  localparam logic [ADDR_W-1:0] GRID_A   = ADDR_W'(GRID_W);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(CELLS - GRID_W);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(GRID_W - 1);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_HOME   = ADDR_W'(11);
  localparam logic [ADDR_W-1:0] B_HOME   = ADDR_W'(88);
  localparam logic [1:0] CODE_EMPTY = 2'd0;
  localparam logic [1:0] CODE_A     = 2'd2;
  localparam logic [1:0] CODE_B     = 2'd3;
  localparam logic [2:0] CMD_UP     = 3'd0;
  localparam logic [2:0] CMD_DOWN   = 3'd1;
  localparam logic [2:0] CMD_LEFT   = 3'd2;
  localparam logic [2:0] CMD_RIGHT  = 3'd3;
  localparam logic [2:0] CMD_BOMB   = 3'd4;

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic                who_q, who_d;
  logic [ADDR_W-1:0]   tgt_q, tgt_d;
  logic [ADDR_W-1:0]   a_pos_q, a_pos_d;
  logic [ADDR_W-1:0]   b_pos_q, b_pos_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_wr_en_q, mem_wr_en_d;
  logic [1:0]          mem_wr_data_q, mem_wr_data_d;
  logic                bomb_wr_en_q, bomb_wr_en_d;
  logic                prefer_b_q, prefer_b_d;
  logic                x_won_q, x_won_d;

  logic                idle_c, pl_req_c, pick_b_c;
  logic                x_gnt_c, a_gnt_c, b_gnt_c;
  logic [ADDR_W-1:0]   sel_pos_c, col_c, mv_tgt_c, old_pos_c;
  logic [2:0]          sel_cmd_c;
  logic                mv_rej_c, blocked_c, p_done_c, p_ok_c;

`ifdef BOMB_BLOCKS_MOVE_EN
  assign blocked_c = (mem_rd_data != CODE_EMPTY) || bomb_rd_data;
`else
  logic unused_bomb_rd;
  assign unused_bomb_rd = bomb_rd_data;
  assign blocked_c      = (mem_rd_data != CODE_EMPTY);
`endif

  // Grant: explosion first unless it won the previous IDLE while a player waited
  always_comb begin
    idle_c   = (state_q == IDLE) && !rst;
    pl_req_c = !game_over && (a_valid || b_valid);
    pick_b_c = b_valid && (!a_valid || prefer_b_q);
    x_gnt_c  = idle_c && x_valid && !(x_won_q && pl_req_c);
    a_gnt_c  = idle_c && !x_gnt_c && !game_over && a_valid && !pick_b_c;
    b_gnt_c  = idle_c && !x_gnt_c && !game_over && pick_b_c;
  end

  // Move target and boundary rejection, checked before any subtraction
  always_comb begin
    sel_pos_c = pick_b_c ? b_pos_q : a_pos_q;
    sel_cmd_c = pick_b_c ? b_cmd : a_cmd;
    col_c     = sel_pos_c % GRID_A;
    mv_tgt_c  = sel_pos_c;
    mv_rej_c  = 1'b1;
    case (sel_cmd_c)
      CMD_UP: begin
        mv_rej_c = (sel_pos_c < GRID_A);
        mv_tgt_c = sel_pos_c - GRID_A;
      end
      CMD_DOWN: begin
        mv_rej_c = (sel_pos_c >= ROW_LAST);
        mv_tgt_c = sel_pos_c + GRID_A;
      end
      CMD_LEFT: begin
        mv_rej_c = (col_c == '0);
        mv_tgt_c = sel_pos_c - ONE_A;
      end
      CMD_RIGHT: begin
        mv_rej_c = (col_c == COL_LAST);
        mv_tgt_c = sel_pos_c + ONE_A;
      end
      default: begin
        mv_rej_c = 1'b1;
        mv_tgt_c = sel_pos_c;
      end
    endcase
  end

  assign old_pos_c = who_q ? b_pos_q : a_pos_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      op_q          <= OP_MOVE;
      who_q         <= 1'b0;
      tgt_q         <= '0;
      a_pos_q       <= A_HOME;
      b_pos_q       <= B_HOME;
      mem_addr_q    <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_data_q <= '0;
      bomb_wr_en_q  <= 1'b0;
      prefer_b_q    <= 1'b0;
      x_won_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      who_q         <= who_d;
      tgt_q         <= tgt_d;
      a_pos_q       <= a_pos_d;
      b_pos_q       <= b_pos_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_data_q <= mem_wr_data_d;
      bomb_wr_en_q  <= bomb_wr_en_d;
      prefer_b_q    <= prefer_b_d;
      x_won_q       <= x_won_d;
    end
  end

  // Sequencer: write strobes are registered one state ahead so they line up with WR_NEW/WR_OLD
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    who_d         = who_q;
    tgt_d         = tgt_q;
    a_pos_d       = a_pos_q;
    b_pos_d       = b_pos_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_en_d   = 1'b0;
    mem_wr_data_d = CODE_EMPTY;
    bomb_wr_en_d  = 1'b0;
    prefer_b_d    = prefer_b_q;
    x_won_d       = x_won_q;
    p_done_c      = 1'b0;
    p_ok_c        = 1'b0;
    x_done        = 1'b0;
    hit_a         = 1'b0;
    hit_b         = 1'b0;

    case (state_q)
      IDLE: begin
        if (x_gnt_c) begin
          op_d       = OP_X;
          tgt_d      = x_addr;
          mem_addr_d = x_addr;
          x_won_d    = pl_req_c;
          state_d    = RD;
        end else if (a_gnt_c || b_gnt_c) begin
          who_d      = b_gnt_c;
          prefer_b_d = a_gnt_c;
          x_won_d    = 1'b0;
          if (sel_cmd_c == CMD_BOMB) begin
            op_d         = OP_BOMB;
            mem_addr_d   = sel_pos_c;
            bomb_wr_en_d = 1'b1;
            state_d      = WR_NEW;
          end else if (mv_rej_c) begin
            op_d    = OP_REJ;
            state_d = CHK;
          end else begin
            op_d       = OP_MOVE;
            tgt_d      = mv_tgt_c;
            mem_addr_d = mv_tgt_c;
            state_d    = RD;
          end
        end
      end
      RD: state_d = CHK;
      CHK: begin
        case (op_q)
          OP_MOVE: begin
            if (blocked_c) begin
              p_done_c = 1'b1;
              state_d  = IDLE;
            end else begin
              mem_wr_en_d   = 1'b1;
              mem_wr_data_d = who_q ? CODE_B : CODE_A;
              mem_addr_d    = tgt_q;
              state_d       = WR_NEW;
            end
          end
          OP_X: begin
            if (mem_rd_data == CODE_A || mem_rd_data == CODE_B) begin
              hit_a   = (mem_rd_data == CODE_A);
              hit_b   = (mem_rd_data == CODE_B);
              x_done  = 1'b1;
              state_d = IDLE;
            end else begin
              mem_wr_en_d   = 1'b1;
              mem_wr_data_d = CODE_EMPTY;
              mem_addr_d    = tgt_q;
              state_d       = WR_NEW;
            end
          end
          default: begin
            p_done_c = 1'b1;
            state_d  = IDLE;
          end
        endcase
      end
      WR_NEW: begin
        if (op_q == OP_MOVE) begin
          mem_wr_en_d   = 1'b1;
          mem_wr_data_d = CODE_EMPTY;
          mem_addr_d    = old_pos_c;
          state_d       = WR_OLD;
        end else begin
          x_done   = (op_q == OP_X);
          p_done_c = (op_q == OP_BOMB);
          p_ok_c   = (op_q == OP_BOMB);
          state_d  = IDLE;
        end
      end
      WR_OLD: begin
        p_done_c = 1'b1;
        p_ok_c   = 1'b1;
        if (who_q) b_pos_d = tgt_q;
        else       a_pos_d = tgt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign a_ready     = a_gnt_c;
  assign b_ready     = b_gnt_c;
  assign x_ready     = x_gnt_c;
  assign a_done      = p_done_c && !who_q;
  assign b_done      = p_done_c && who_q;
  assign a_ok        = p_ok_c && !who_q;
  assign b_ok        = p_ok_c && who_q;
  assign a_pos       = a_pos_q;
  assign b_pos       = b_pos_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_wr_data = mem_wr_data_q;
  assign bomb_wr_en  = bomb_wr_en_q;

endmodule

// File: tb/tb_arena_access_arbiter.sv
// Directed bench for arena_access_arbiter with a one-cycle-latency arena/bomb map model.
module tb_arena_access_arbiter;

  logic       clk = 1'b0;
  logic       rst, game_over;
  logic       a_valid, b_valid, x_valid;
  logic [2:0] a_cmd, b_cmd;
  logic [6:0] x_addr;
  logic       a_ready, a_done, a_ok, b_ready, b_done, b_ok;
  logic       x_ready, x_done, hit_a, hit_b;
  logic [6:0] a_pos, b_pos, mem_addr;
  logic [1:0] mem_rd_data, mem_wr_data;
  logic       bomb_rd_data, mem_wr_en, bomb_wr_en;

  logic [1:0] arena [0:99];
  logic       bomb  [0:99];
  logic       init_req;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  arena_access_arbiter dut (
    .clk(clk), .rst(rst), .game_over(game_over),
    .a_valid(a_valid), .a_cmd(a_cmd), .a_ready(a_ready), .a_done(a_done), .a_ok(a_ok),
    .b_valid(b_valid), .b_cmd(b_cmd), .b_ready(b_ready), .b_done(b_done), .b_ok(b_ok),
    .x_valid(x_valid), .x_addr(x_addr), .x_ready(x_ready), .x_done(x_done),
    .hit_a(hit_a), .hit_b(hit_b), .a_pos(a_pos), .b_pos(b_pos),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .bomb_rd_data(bomb_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .bomb_wr_en(bomb_wr_en)
  );

  // Map storage: A at 11, B at 88, a block at 21
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 100; i++) begin
        arena[i] <= 2'd0;
        bomb[i]  <= 1'b0;
      end
      arena[11] <= 2'd2;
      arena[88] <= 2'd3;
      arena[21] <= 2'd1;
    end else begin
      mem_rd_data  <= arena[mem_addr];
      bomb_rd_data <= bomb[mem_addr];
      if (mem_wr_en)  arena[mem_addr] <= mem_wr_data;
      if (bomb_wr_en) bomb[mem_addr]  <= 1'b1;
    end
  end

  task automatic do_reset();
    rst = 1'b1; init_req = 1'b1; game_over = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; x_valid = 1'b0;
    a_cmd = 3'd0; b_cmd = 3'd0; x_addr = 7'd0;
    repeat (3) @(negedge clk);
    init_req = 1'b0; rst = 1'b0;
  endtask

  task automatic player_op(input logic is_b, input logic [2:0] cmd, output logic ok);
    int n;
    @(negedge clk);
    if (is_b) begin b_valid = 1'b1; b_cmd = cmd; end
    else      begin a_valid = 1'b1; a_cmd = cmd; end
    #1;
    n = 0;
    while (!(is_b ? b_ready : a_ready) && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) begin tests_run++; tests_failed++; $display("FAIL grant_timeout: player %0d not granted within 20 cycles", is_b); end
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    n = 0;
    while (!(is_b ? b_done : a_done) && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) begin tests_run++; tests_failed++; $display("FAIL done_timeout: player %0d no done within 20 cycles", is_b); end
    ok = is_b ? b_ok : a_ok;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; init_req = 1'b1; game_over = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; x_valid = 1'b0;
    a_cmd = 3'd0; b_cmd = 3'd0; x_addr = 7'd0;
    repeat (2) @(negedge clk);
    #1;
    tests_run++; if (a_pos !== 7'd11) begin tests_failed++; $display("FAIL reset_a_pos: got %0d, want 11", a_pos); end
    tests_run++; if (b_pos !== 7'd88) begin tests_failed++; $display("FAIL reset_b_pos: got %0d, want 88", b_pos); end
    tests_run++; if (mem_addr !== 7'd0) begin tests_failed++; $display("FAIL reset_mem_addr: got %0d, want 0", mem_addr); end
    tests_run++; if ({mem_wr_en, bomb_wr_en, mem_wr_data} !== 4'd0) begin tests_failed++; $display("FAIL reset_strobes: got %b%b%b, want 0000", mem_wr_en, bomb_wr_en, mem_wr_data); end
    tests_run++; if ({a_ready, b_ready, x_ready, a_done, b_done, x_done, hit_a, hit_b} !== 8'd0) begin tests_failed++; $display("FAIL reset_flags: some ready/done/hit high"); end
    @(negedge clk);
    init_req = 1'b0; rst = 1'b0;
  endtask

  task automatic test_move_right();
    @(negedge clk); a_valid = 1'b1; a_cmd = 3'd3; #1;
    tests_run++; if (a_ready !== 1'b1) begin tests_failed++; $display("FAIL mv_ready: got %b, want 1", a_ready); end
    @(negedge clk); a_valid = 1'b0; #1;
    tests_run++; if (mem_addr !== 7'd12 || mem_wr_en !== 1'b0) begin tests_failed++; $display("FAIL mv_t1: addr %0d wr %b, want 12/0", mem_addr, mem_wr_en); end
    @(negedge clk); #1;
    tests_run++; if (mem_wr_en !== 1'b0 || a_done !== 1'b0) begin tests_failed++; $display("FAIL mv_t2: wr %b done %b, want 0/0", mem_wr_en, a_done); end
    @(negedge clk); #1;
    tests_run++; if (mem_wr_en !== 1'b1 || mem_addr !== 7'd12 || mem_wr_data !== 2'd2) begin tests_failed++; $display("FAIL mv_t3: wr %b addr %0d data %0d, want 1/12/2", mem_wr_en, mem_addr, mem_wr_data); end
    @(negedge clk); #1;
    tests_run++; if (mem_wr_en !== 1'b1 || mem_addr !== 7'd11 || mem_wr_data !== 2'd0) begin tests_failed++; $display("FAIL mv_t4: wr %b addr %0d data %0d, want 1/11/0", mem_wr_en, mem_addr, mem_wr_data); end
    tests_run++; if (a_done !== 1'b1 || a_ok !== 1'b1) begin tests_failed++; $display("FAIL mv_done: done %b ok %b, want 1/1", a_done, a_ok); end
    @(negedge clk); #1;
    tests_run++; if (a_pos !== 7'd12 || a_done !== 1'b0) begin tests_failed++; $display("FAIL mv_t5: pos %0d done %b, want 12/0", a_pos, a_done); end
    tests_run++; if (arena[12] !== 2'd2 || arena[11] !== 2'd0) begin tests_failed++; $display("FAIL mv_arena: [12]=%0d [11]=%0d, want 2/0", arena[12], arena[11]); end
  endtask

  task automatic test_block_down();
    logic ok;
    player_op(1'b0, 3'd2, ok);
    tests_run++; if (ok !== 1'b1 || a_pos !== 7'd11) begin tests_failed++; $display("FAIL left_back: ok %b pos %0d, want 1/11", ok, a_pos); end
    @(negedge clk); a_valid = 1'b1; a_cmd = 3'd1; #1;
    tests_run++; if (a_ready !== 1'b1) begin tests_failed++; $display("FAIL blk_ready: got %b, want 1", a_ready); end
    @(negedge clk); a_valid = 1'b0; #1;
    tests_run++; if (mem_addr !== 7'd21 || a_done !== 1'b0) begin tests_failed++; $display("FAIL blk_t1: addr %0d done %b, want 21/0", mem_addr, a_done); end
    @(negedge clk); #1;
    tests_run++; if (a_done !== 1'b1 || a_ok !== 1'b0 || mem_wr_en !== 1'b0) begin tests_failed++; $display("FAIL blk_t2: done %b ok %b wr %b, want 1/0/0", a_done, a_ok, mem_wr_en); end
    @(negedge clk); #1;
    tests_run++; if (mem_wr_en !== 1'b0 || a_done !== 1'b0 || a_pos !== 7'd11) begin tests_failed++; $display("FAIL blk_t3: wr %b done %b pos %0d, want 0/0/11", mem_wr_en, a_done, a_pos); end
  endtask

  task automatic test_boundary();
    logic ok;
    player_op(1'b0, 3'd0, ok);
    for (int i = 0; i < 4; i++) player_op(1'b0, 3'd3, ok);
    tests_run++; if (a_pos !== 7'd5) begin tests_failed++; $display("FAIL walk_to_5: pos %0d, want 5", a_pos); end
    @(negedge clk); a_valid = 1'b1; a_cmd = 3'd0; #1;
    @(negedge clk); a_valid = 1'b0; #1;
    tests_run++; if (a_done !== 1'b1 || a_ok !== 1'b0 || mem_wr_en !== 1'b0) begin tests_failed++; $display("FAIL up_edge_t1: done %b ok %b wr %b, want 1/0/0", a_done, a_ok, mem_wr_en); end
    @(negedge clk); #1;
    tests_run++; if (a_done !== 1'b0 || a_pos !== 7'd5 || mem_wr_en !== 1'b0) begin tests_failed++; $display("FAIL up_edge_t2: done %b pos %0d wr %b, want 0/5/0", a_done, a_pos, mem_wr_en); end
    @(negedge clk); b_valid = 1'b1; b_cmd = 3'd7; #1;
    @(negedge clk); b_valid = 1'b0; #1;
    tests_run++; if (b_done !== 1'b1 || b_ok !== 1'b0 || a_done !== 1'b0) begin tests_failed++; $display("FAIL illegal: b_done %b b_ok %b a_done %b, want 1/0/0", b_done, b_ok, a_done); end
    @(negedge clk); a_valid = 1'b1; a_cmd = 3'd4; #1;
    @(negedge clk); a_valid = 1'b0; #1;
    tests_run++; if (bomb_wr_en !== 1'b1 || mem_addr !== 7'd5 || mem_wr_en !== 1'b0) begin tests_failed++; $display("FAIL bomb_t1: bwr %b addr %0d wr %b, want 1/5/0", bomb_wr_en, mem_addr, mem_wr_en); end
    tests_run++; if (a_done !== 1'b1 || a_ok !== 1'b1) begin tests_failed++; $display("FAIL bomb_done: done %b ok %b, want 1/1", a_done, a_ok); end
    @(negedge clk); #1;
    tests_run++; if (bomb_wr_en !== 1'b0 || bomb[5] !== 1'b1) begin tests_failed++; $display("FAIL bomb_t2: bwr %b map %b, want 0/1", bomb_wr_en, bomb[5]); end
  endtask

  task automatic test_explosion();
    @(negedge clk); x_valid = 1'b1; x_addr = 7'd88; #1;
    tests_run++; if (x_ready !== 1'b1) begin tests_failed++; $display("FAIL x_ready: got %b, want 1", x_ready); end
    @(negedge clk); x_valid = 1'b0; #1;
    @(negedge clk); #1;
    tests_run++; if (hit_b !== 1'b1 || hit_a !== 1'b0 || x_done !== 1'b1 || mem_wr_en !== 1'b0) begin tests_failed++; $display("FAIL xb_t2: hb %b ha %b xd %b wr %b, want 1/0/1/0", hit_b, hit_a, x_done, mem_wr_en); end
    @(negedge clk); #1;
    tests_run++; if (hit_b !== 1'b0 || mem_wr_en !== 1'b0 || arena[88] !== 2'd3) begin tests_failed++; $display("FAIL xb_t3: hb %b wr %b cell %0d, want 0/0/3", hit_b, mem_wr_en, arena[88]); end
    @(negedge clk); x_valid = 1'b1; x_addr = 7'd21; #1;
    @(negedge clk); x_valid = 1'b0; #1;
    @(negedge clk); #1;
    tests_run++; if (hit_a !== 1'b0 || hit_b !== 1'b0 || x_done !== 1'b0) begin tests_failed++; $display("FAIL xblk_t2: ha %b hb %b xd %b, want 0/0/0", hit_a, hit_b, x_done); end
    @(negedge clk); #1;
    tests_run++; if (mem_wr_en !== 1'b1 || mem_addr !== 7'd21 || mem_wr_data !== 2'd0 || x_done !== 1'b1) begin tests_failed++; $display("FAIL xblk_t3: wr %b addr %0d data %0d xd %b, want 1/21/0/1", mem_wr_en, mem_addr, mem_wr_data, x_done); end
    @(negedge clk); #1;
    tests_run++; if (mem_wr_en !== 1'b0 || arena[21] !== 2'd0) begin tests_failed++; $display("FAIL xblk_t4: wr %b cell %0d, want 0/0", mem_wr_en, arena[21]); end
    @(negedge clk); x_valid = 1'b1; x_addr = 7'd5; #1;
    @(negedge clk); x_valid = 1'b0; #1;
    @(negedge clk); #1;
    tests_run++; if (hit_a !== 1'b1 || hit_b !== 1'b0) begin tests_failed++; $display("FAIL xa_t2: ha %b hb %b, want 1/0", hit_a, hit_b); end
    @(negedge clk);
  endtask

  task automatic test_move_b();
    @(negedge clk); b_valid = 1'b1; b_cmd = 3'd0; #1;
    tests_run++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin tests_failed++; $display("FAIL b_ready: b %b a %b, want 1/0", b_ready, a_ready); end
    @(negedge clk); b_valid = 1'b0; #1;
    tests_run++; if (mem_addr !== 7'd78) begin tests_failed++; $display("FAIL b_t1: addr %0d, want 78", mem_addr); end
    @(negedge clk); @(negedge clk); #1;
    tests_run++; if (mem_wr_en !== 1'b1 || mem_addr !== 7'd78 || mem_wr_data !== 2'd3) begin tests_failed++; $display("FAIL b_t3: wr %b addr %0d data %0d, want 1/78/3", mem_wr_en, mem_addr, mem_wr_data); end
    @(negedge clk); #1;
    tests_run++; if (mem_addr !== 7'd88 || b_done !== 1'b1 || b_ok !== 1'b1 || a_done !== 1'b0) begin tests_failed++; $display("FAIL b_t4: addr %0d bd %b bok %b ad %b, want 88/1/1/0", mem_addr, b_done, b_ok, a_done); end
    @(negedge clk); #1;
    tests_run++; if (b_pos !== 7'd78 || arena[78] !== 2'd3 || arena[88] !== 2'd0) begin tests_failed++; $display("FAIL b_t5: pos %0d [78]=%0d [88]=%0d, want 78/3/0", b_pos, arena[78], arena[88]); end
  endtask

  task automatic test_priority();
    int ga = -1, gb = -1, both = 0;
    do_reset();
    @(negedge clk);
    x_valid = 1'b1; x_addr = 7'd50; a_valid = 1'b1; a_cmd = 3'd6; b_valid = 1'b1; b_cmd = 3'd6; #1;
    tests_run++; if (x_ready !== 1'b1 || a_ready !== 1'b0 || b_ready !== 1'b0) begin tests_failed++; $display("FAIL prio_t0: x %b a %b b %b, want 1/0/0", x_ready, a_ready, b_ready); end
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      x_valid = 1'b0;
      if (ga >= 0) a_valid = 1'b0;
      if (gb >= 0) b_valid = 1'b0;
      #1;
      if (a_ready && b_ready) both++;
      if (a_ready && ga < 0) ga = c;
      if (b_ready && gb < 0) gb = c;
    end
    tests_run++; if (ga !== 4 || gb !== 6) begin tests_failed++; $display("FAIL prio_order: A at %0d B at %0d, want 4/6", ga, gb); end
    tests_run++; if (both !== 0) begin tests_failed++; $display("FAIL prio_exclusive: both ready %0d times, want 0", both); end
  endtask

  task automatic test_no_starve();
    int ga = -1;
    logic xr4 = 1'b1, xr6 = 1'b0;
    @(negedge clk);
    x_valid = 1'b1; x_addr = 7'd50; a_valid = 1'b1; a_cmd = 3'd6; #1;
    tests_run++; if (x_ready !== 1'b1 || a_ready !== 1'b0) begin tests_failed++; $display("FAIL starve_t0: x %b a %b, want 1/0", x_ready, a_ready); end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (ga >= 0) a_valid = 1'b0;
      #1;
      if (a_ready && ga < 0) ga = c;
      if (c == 4) xr4 = x_ready;
      if (c == 6) xr6 = x_ready;
    end
    @(negedge clk); x_valid = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++; if (ga !== 4 || xr4 !== 1'b0) begin tests_failed++; $display("FAIL starve_player: A at %0d x_ready %b, want 4/0", ga, xr4); end
    tests_run++; if (xr6 !== 1'b1) begin tests_failed++; $display("FAIL starve_x_next: x_ready %b, want 1", xr6); end
  endtask

  task automatic test_game_over();
    @(negedge clk);
    game_over = 1'b1; a_valid = 1'b1; a_cmd = 3'd6; b_valid = 1'b1; b_cmd = 3'd6;
    x_valid = 1'b1; x_addr = 7'd50; #1;
    tests_run++; if (x_ready !== 1'b1 || a_ready !== 1'b0 || b_ready !== 1'b0) begin tests_failed++; $display("FAIL go_t0: x %b a %b b %b, want 1/0/0", x_ready, a_ready, b_ready); end
    @(negedge clk); x_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    tests_run++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin tests_failed++; $display("FAIL go_idle: a %b b %b, want 0/0", a_ready, b_ready); end
    a_valid = 1'b0; b_valid = 1'b0; game_over = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk); a_valid = 1'b1; a_cmd = 3'd3;
    @(negedge clk); a_valid = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    tests_run++; if (mem_wr_en !== 1'b1) begin tests_failed++; $display("FAIL rmid_wrnew: wr %b, want 1", mem_wr_en); end
    rst = 1'b1; #1;
    tests_run++; if (mem_wr_en !== 1'b0 || a_pos !== 7'd11 || b_pos !== 7'd88) begin tests_failed++; $display("FAIL rmid_async: wr %b a %0d b %0d, want 0/11/88", mem_wr_en, a_pos, b_pos); end
    @(negedge clk); @(negedge clk); #1;
    tests_run++; if (mem_wr_en !== 1'b0 || arena[12] !== 2'd0 || arena[11] !== 2'd2) begin tests_failed++; $display("FAIL rmid_nowrite: wr %b [12]=%0d [11]=%0d, want 0/0/2", mem_wr_en, arena[12], arena[11]); end
    rst = 1'b0;
    @(negedge clk); a_valid = 1'b1; a_cmd = 3'd6; #1;
    tests_run++; if (a_ready !== 1'b1) begin tests_failed++; $display("FAIL rmid_resume: ready %b, want 1", a_ready); end
    @(negedge clk); a_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_move_right();
    test_block_down();
    test_boundary();
    test_explosion();
    test_move_b();
    test_priority();
    test_no_starve();
    test_game_over();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
